// File: rtl/en_tick_gen.sv
// -----------------------------------------------------------------------------
// en_tick_gen
//
// Prescaled enable-pulse generator for a downstream counter. Once started it
// issues a one-cycle `en` pulse every div+1 clock cycles. It either free-runs
// until stopped, or (oneshot) issues a fixed burst of pulses and then signals
// completion with a one-cycle `done` pulse.
//
// Parameters
//   DIV_W     width of the prescaler divide ratio
//
// Ports
//   clk       sole clock, rising edge
//   reset     synchronous, active-high reset
//   start     level-sampled request to begin ticking (accepted in IDLE only)
//   stop      level-sampled abort request (wins over start in IDLE)
//   oneshot   0 = free-run, 1 = burst; sampled only when start is accepted
//   div       divide ratio, tick period = div+1 cycles
//   burst     oneshot pulse count, 0 encodes 16
//   en        registered one-cycle enable pulse
//   busy      registered, high while in RUN
//   done      registered one-cycle burst-completion pulse
//   tick_cnt  registered count (mod 16) of en pulses since the last start
// -----------------------------------------------------------------------------
module en_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       burst,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic [3:0]       tick_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] PRE_ONE = DIV_W'(1);

    state_t           state, state_n;
    logic [DIV_W-1:0] pre, pre_n;     // prescaler, equals 0 in the cycle en is high
    logic [DIV_W-1:0] pre_nx;         // prescaler advance when RUN continues
    logic [4:0]       bcnt, bcnt_n;   // pulses remaining in the burst (1..16)
    logic             mode, mode_n;   // latched oneshot
    logic             en_n, busy_n, done_n;
    logic [3:0]       tick_n;

    // Reload from the live div only when the prescaler has hit zero, so a div
    // change mid-run first affects the period that starts at the next reload.
    assign pre_nx = (pre == '0) ? div : (pre - PRE_ONE);

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        pre_n   = pre;
        bcnt_n  = bcnt;
        mode_n  = mode;
        tick_n  = tick_cnt;
        en_n    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n = RUN;
                    pre_n   = div;
                    bcnt_n  = (burst == 4'd0) ? 5'd16 : {1'b0, burst};
                    mode_n  = oneshot;
                    // With div=0 the prescaler is already expired on entry,
                    // so the very first RUN cycle carries a pulse.
                    en_n    = (div == '0);
                    tick_n  = {3'b000, en_n};
                end
            end

            RUN: begin
                if (stop) begin
                    // Abort suppresses any pulse, even on an expiry cycle.
                    state_n = IDLE;
                end else if (mode && en && (bcnt == 5'd1)) begin
                    // This cycle carries the final burst pulse.
                    state_n = DONE;
                    bcnt_n  = 5'd0;
                end else begin
                    if (mode && en) begin
                        bcnt_n = bcnt - 5'd1;
                    end
                    pre_n = pre_nx;
                    // en is registered, so it is raised in the same cycle the
                    // prescaler reads zero.
                    en_n  = (pre_nx == '0);
                    if (en_n) begin
                        tick_n = tick_cnt + 4'd1;
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pre      <= '0;
            bcnt     <= 5'd0;
            mode     <= 1'b0;
            tick_cnt <= 4'd0;
            en       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            pre      <= pre_n;
            bcnt     <= bcnt_n;
            mode     <= mode_n;
            tick_cnt <= tick_n;
            en       <= en_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_en_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_en_tick_gen
//
// Scoreboard bench for en_tick_gen. Each driven cycle the reference model
// predicts the outputs visible after the next rising edge and queues them,
// tagged with that cycle number; a monitor on the falling edge pops and
// compares. The model schedules pulses by absolute cycle number ("next pulse
// due at cycle N") rather than by a down-counting prescaler.
// -----------------------------------------------------------------------------
module tb_en_tick_gen;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset, start, stop, oneshot;
    logic [DIV_W-1:0] div;
    logic [3:0]       burst;
    logic             en, busy, done;
    logic [3:0]       tick_cnt;

    en_tick_gen #(.DIV_W(DIV_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .oneshot  (oneshot),
        .div      (div),
        .burst    (burst),
        .en       (en),
        .busy     (busy),
        .done     (done),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        logic       en;
        logic       busy;
        logic       done;
        logic [3:0] tick;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    int m_st    = M_IDLE;
    int m_c     = 0;   // cycle whose inputs are being applied
    int m_due   = -1;  // absolute cycle of the next en pulse
    int m_left  = 0;   // burst pulses still to issue
    int m_ticks = 0;
    bit m_mode  = 1'b0;

    function automatic bit en_now();
        return (m_st == M_RUN) && (m_c == m_due);
    endfunction

    task automatic model_step(input bit r, input bit st, input bit sp,
                              input bit os, input int d, input int b);
        bit   en_cur, en_nx;
        exp_t e;
        en_cur = en_now();
        en_nx  = 1'b0;
        if (r) begin
            m_st    = M_IDLE;
            m_ticks = 0;
            m_due   = -1;
        end else begin
            case (m_st)
                M_IDLE: if (st && !sp) begin
                    m_st    = M_RUN;
                    m_due   = m_c + d + 1;
                    m_ticks = 0;
                    m_left  = (b == 0) ? 16 : b;
                    m_mode  = os;
                    en_nx   = (m_c + 1 == m_due);
                end
                M_RUN: begin
                    if (sp) begin
                        m_st = M_IDLE;
                    end else if (m_mode && en_cur && m_left == 1) begin
                        m_st = M_DONE;
                    end else begin
                        if (en_cur) begin
                            if (m_mode) m_left--;
                            m_due = m_c + d + 1;
                        end
                        en_nx = (m_c + 1 == m_due);
                    end
                end
                default: m_st = M_IDLE;
            endcase
            if (en_nx) m_ticks = (m_ticks + 1) % 16;
        end
        e.tag  = m_c + 1;
        e.en   = en_nx;
        e.busy = (m_st == M_RUN);
        e.done = (m_st == M_DONE);
        e.tick = 4'(m_ticks);
        q.push_back(e);
        m_c++;
    endtask

    // ---------------- driver ----------------
    task automatic cyc_in(input bit r, input bit st, input bit sp,
                          input bit os, input int d, input int b);
        reset   = r;
        start   = st;
        stop    = sp;
        oneshot = os;
        div     = DIV_W'(d);
        burst   = 4'(b);
        model_step(r, st, sp, os, d, b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n, input int d, input int b);
        for (int i = 0; i < n; i++) cyc_in(1'b0, 1'b0, 1'b0, 1'b0, d, b);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].tag == cyc) begin
            e = q.pop_front();
            n_cmp++;
            if ({en, busy, done, tick_cnt} !== {e.en, e.busy, e.done, e.tick}) begin
                n_bad++;
                $display("FAIL outputs@cycle%0d: got en=%b busy=%b done=%b tick=%0d, expected en=%b busy=%b done=%b tick=%0d",
                         cyc, en, busy, done, tick_cnt, e.en, e.busy, e.done, e.tick);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int tries;
        // Reset for two cycles, then free-run at div=3.
        cyc_in(1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
        cyc_in(1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
        cyc_in(1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
        idle_n(20, 3, 0);
        cyc_in(1'b0, 1'b0, 1'b1, 1'b0, 3, 0);
        idle_n(2, 3, 0);

        // Burst of 5 at div=0: back-to-back pulses, then done.
        cyc_in(1'b0, 1'b1, 1'b0, 1'b1, 0, 5);
        idle_n(10, 0, 5);

        // Free-run div=1 past the tick_cnt wrap, then stop on a pulse cycle.
        cyc_in(1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
        idle_n(36, 1, 0);
        tries = 0;
        while (!en_now() && tries < 8) begin
            cyc_in(1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
            tries++;
        end
        cyc_in(1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        idle_n(4, 1, 0);

        // start+stop together in IDLE is refused; start during RUN is ignored.
        cyc_in(1'b0, 1'b1, 1'b1, 1'b0, 2, 0);
        idle_n(3, 2, 0);
        cyc_in(1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
        idle_n(5, 2, 0);
        cyc_in(1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
        idle_n(10, 2, 0);
        cyc_in(1'b0, 1'b0, 1'b1, 1'b0, 2, 0);
        idle_n(2, 2, 0);

        // burst=0 means 16 pulses, div=2.
        cyc_in(1'b0, 1'b1, 1'b0, 1'b1, 2, 0);
        idle_n(55, 2, 0);

        // Reset mid-burst after two pulses, then a fresh start is accepted.
        cyc_in(1'b0, 1'b1, 1'b0, 1'b1, 3, 4);
        idle_n(9, 3, 4);
        cyc_in(1'b1, 1'b0, 1'b0, 1'b1, 3, 4);
        idle_n(2, 3, 4);
        cyc_in(1'b0, 1'b1, 1'b0, 1'b1, 1, 2);
        idle_n(10, 1, 2);

        // Randomized traffic, including div changes mid-run.
        for (int i = 0; i < 3000; i++) begin
            cyc_in($urandom_range(0, 199) == 0,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 39) == 0,
                   1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 15)));
        end
        idle_n(3, 0, 0);

        // Let the monitor consume the last prediction, bounded.
        tries = 0;
        while (q.size() > 0 && tries < 5) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
